// File: rtl/mandel_stream_pkg.sv
// mandel_stream_pkg: shared pixel/beat types, FSM states and the iteration palette
package mandel_stream_pkg;
  typedef logic [14:0] pixel555_t;
  typedef logic [23:0] rgb888_t;
  typedef struct packed {
    logic    tuser;
    logic    tlast;
    rgb888_t tdata;
  } axis_beat_t;
  typedef enum logic [0:0] {WAIT_SOF = 1'b0, STREAM = 1'b1} streamer_state_e;
  localparam rgb888_t PALETTE [16] = '{
    24'h421E0F, 24'h19071A, 24'h09012F, 24'h040449,
    24'h000764, 24'h0C2C8A, 24'h1852B1, 24'h397DD1,
    24'h86B5E5, 24'hD3ECF8, 24'hF1E9BF, 24'hF8C95F,
    24'hFFAA00, 24'hCC8000, 24'h995700, 24'h6A3403
  };
  function automatic rgb888_t rgb555_to_888(pixel555_t p);
    return {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
  endfunction
endpackage

// File: rtl/mandelbrot_pixel_streamer_if.sv
// mandelbrot_pixel_streamer_if: raster pixel input and AXI4-Stream video output of the streamer
interface mandelbrot_pixel_streamer_if import mandel_stream_pkg::*;;
  logic      in_valid;
  logic      in_ready;
  pixel555_t in_rgb;
  logic [9:0] in_x;
  logic [9:0] in_y;
  rgb888_t   m_axis_tdata;
  logic      m_axis_tvalid;
  logic      m_axis_tready;
  logic      m_axis_tuser;
  logic      m_axis_tlast;
  modport master (
    output in_valid, in_rgb, in_x, in_y, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );
  modport slave (
    input  in_valid, in_rgb, in_x, in_y, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO of AXI video beats
module stream_fifo import mandel_stream_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  axis_beat_t din,
  output axis_beat_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  axis_beat_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mandelbrot_pixel_streamer.sv
// mandelbrot_pixel_streamer: raster pixels to AXI4-Stream RGB888 video; COLOUR_MAP_EN selects palette mapping
module mandelbrot_pixel_streamer import mandel_stream_pkg::*; #(
  parameter int FIFO_DEPTH = 4
`ifdef COLOUR_MAP_EN
  , parameter pixel555_t MAX_ITER = 15'h7FFF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] x_size,
  input  logic [9:0] y_size,
  mandelbrot_pixel_streamer_if.slave io,
  output logic       frame_done,
  output logic       sync_err
);
  streamer_state_e state;
  logic [9:0] ex, ey, x_w, y_h, cx, cy, lx, ly;
  logic full, empty, acc, sof, hit, take, eol, eof;
  rgb888_t colour;
  axis_beat_t beat, head;
  assign io.in_ready = enable && !full;
  assign acc  = io.in_valid && io.in_ready;
  // Outside a frame the expected position is the origin and the geometry is the live size inputs
  assign cx   = state == STREAM ? ex : '0;
  assign cy   = state == STREAM ? ey : '0;
  assign lx   = state == STREAM ? x_w - 10'd1 : x_size - 10'd1;
  assign ly   = state == STREAM ? y_h - 10'd1 : y_size - 10'd1;
  assign sof  = io.in_x == '0 && io.in_y == '0 && x_size != '0 && y_size != '0;
  assign hit  = io.in_x == cx && io.in_y == cy;
  assign take = acc && (state == STREAM ? hit : sof);
  assign eol  = cx == lx;
  assign eof  = eol && cy == ly;
`ifdef COLOUR_MAP_EN
  assign colour = io.in_rgb == MAX_ITER ? '0 : PALETTE[io.in_rgb[3:0]];
`else
  assign colour = rgb555_to_888(io.in_rgb);
`endif
  assign beat = '{tuser: state == WAIT_SOF, tlast: eol, tdata: colour};
  stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (take),
    .pop   (io.m_axis_tvalid && io.m_axis_tready),
    .din   (beat),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign io.m_axis_tvalid = !empty;
  assign io.m_axis_tdata  = head.tdata;
  assign io.m_axis_tuser  = head.tuser;
  assign io.m_axis_tlast  = head.tlast;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WAIT_SOF;
      ex         <= '0;
      ey         <= '0;
      x_w        <= '0;
      y_h        <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= take && eof;
      sync_err   <= acc && state == STREAM && !hit;
      if (acc) state <= (take && !eof) ? STREAM : WAIT_SOF;
      if (take) begin
        ex <= eol ? '0 : cx + 10'd1;
        ey <= eol ? cy + 10'd1 : cy;
      end
      if (take && state == WAIT_SOF) begin
        x_w <= x_size;
        y_h <= y_size;
      end
    end
  end
endmodule

// File: tb/tb_mandelbrot_pixel_streamer.sv
// tb_mandelbrot_pixel_streamer: directed and random pixel streams checked against a frame-index model
module tb_mandelbrot_pixel_streamer;
  import mandel_stream_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [14:0] rgb;
  } pix_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [9:0] x_size = 10'd2;
  logic [9:0] y_size = 10'd2;
  logic frame_done, sync_err;
  mandelbrot_pixel_streamer_if io ();
  mandelbrot_pixel_streamer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .x_size     (x_size),
    .y_size     (y_size),
    .io         (io),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  pix_t script[$];
  axis_beat_t q[$];
  bit in_frame = 0;
  int k = 0, w = 1, h = 1;
  bit exp_done = 0, exp_err = 0;
  int tready_mode = 1;
  bit rand_fill = 0;
  int gk = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic rgb888_t ref_colour(logic [14:0] v);
`ifdef COLOUR_MAP_EN
    if (v == 15'h7FFF) return '0;
    return PALETTE[int'(v) % 16];
`else
    int r, g, b;
    r = int'(v) / 1024;
    g = (int'(v) / 32) % 32;
    b = int'(v) % 32;
    return {8'(r * 8 + r / 4), 8'(g * 8 + g / 4), 8'(b * 8 + b / 4)};
`endif
  endfunction
  // Frame position is a linear index k; the expected coordinate is (k mod w, k div w)
  task automatic emit(pix_t p);
    axis_beat_t b;
    b.tuser = k == 0;
    b.tlast = (k % w) == w - 1;
    b.tdata = ref_colour(p.rgb);
    q.push_back(b);
    k++;
    in_frame = k < w * h;
    if (!in_frame) exp_done = 1;
  endtask
  task automatic accept(pix_t p);
    if (!in_frame) begin
      if (p.x == 0 && p.y == 0 && x_size != 0 && y_size != 0) begin
        w = int'(x_size);
        h = int'(y_size);
        k = 0;
        emit(p);
      end
    end else if (int'(p.x) == k % w && int'(p.y) == k / w) begin
      emit(p);
    end else begin
      exp_err = 1;
      in_frame = 0;
    end
  endtask
  task automatic gen_pixel(output pix_t p);
    int gw, gh;
    if (gk == 0 && $urandom_range(3) == 0) begin
      x_size = 10'($urandom_range(4));
      y_size = 10'($urandom_range(3));
    end
    gw = x_size == 0 ? 1 : int'(x_size);
    gh = y_size == 0 ? 1 : int'(y_size);
    if ($urandom_range(11) == 0) begin
      p.x = 10'($urandom_range(4));
      p.y = 10'($urandom_range(3));
    end else begin
      p.x = 10'(gk % gw);
      p.y = 10'(gk / gw);
    end
    gk = (gk + 1) % (gw * gh);
    if ($urandom_range(40) == 0) gk = 0;
    p.rgb = ($urandom_range(5) == 0) ? 15'h7FFF : 15'($urandom);
  endtask
  task automatic cycle();
    bit pop, acc;
    pix_t p;
    @(negedge clk);
    if (rand_fill && script.size() == 0) begin
      gen_pixel(p);
      script.push_back(p);
    end
    io.in_valid = script.size() > 0 && (!rand_fill || $urandom_range(4) != 0);
    if (script.size() > 0) begin
      io.in_x = script[0].x;
      io.in_y = script[0].y;
      io.in_rgb = script[0].rgb;
    end
    io.m_axis_tready = tready_mode == 1 ? 1'b1 : tready_mode == 2 ? 1'($urandom_range(2) != 0) : 1'b0;
    if (rand_fill) enable = $urandom_range(7) != 0;
    #1;
    check("in_ready", io.in_ready, enable && q.size() < DEPTH);
    check("tvalid", io.m_axis_tvalid, q.size() > 0);
    if (q.size() > 0) begin
      check("tdata", io.m_axis_tdata, q[0].tdata);
      check("tuser", io.m_axis_tuser, q[0].tuser);
      check("tlast", io.m_axis_tlast, q[0].tlast);
    end
    check("frame_done", frame_done, exp_done);
    check("sync_err", sync_err, exp_err);
    if (frame_done) n_done++;
    pop = q.size() > 0 && io.m_axis_tready;
    acc = io.in_valid && enable && q.size() < DEPTH;
    exp_done = 0;
    exp_err = 0;
    if (pop) void'(q.pop_front());
    if (acc) accept(script.pop_front());
  endtask
  task automatic drain();
    int n = 0;
    while ((script.size() > 0 || q.size() > 0) && n < 300) begin
      cycle();
      n++;
    end
    check("drain_bound", n < 300, 1'b1);
    repeat (2) cycle();
  endtask
  task automatic add(int x, int y, logic [14:0] rgb);
    pix_t p;
    p.x = 10'(x);
    p.y = 10'(y);
    p.rgb = rgb;
    script.push_back(p);
  endtask
  initial begin
    io.in_valid = 1'b0;
    io.in_x = '0;
    io.in_y = '0;
    io.in_rgb = '0;
    io.m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", io.m_axis_tvalid, 1'b0);
    check("rst_tdata", io.m_axis_tdata, 24'h0);
    check("rst_tuser", io.m_axis_tuser, 1'b0);
    check("rst_tlast", io.m_axis_tlast, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    rst = 1'b1;
    enable = 1'b1;
    x_size = 10'd2;
    y_size = 10'd2;
    add(0, 0, 15'h7FFF); add(1, 0, 15'h7FFF); add(0, 1, 15'h7FFF); add(1, 1, 15'h7FFF);
    drain();
    check("frame_done_count", n_done, 1);
    tready_mode = 0;
    add(0, 0, 15'h1234); add(1, 0, 15'h0013); add(0, 1, 15'h7C00); add(1, 1, 15'h03E0);
    repeat (10) cycle();
    check("bp_buffered", q.size(), DEPTH);
    tready_mode = 1;
    drain();
    x_size = 10'd4;
    add(0, 0, 15'h0013); add(1, 0, 15'h0421); add(0, 1, 15'h5555); add(0, 0, 15'h7FFF);
    drain();
    add(3, 2, 15'h1111); add(1, 1, 15'h2222);
    drain();
    x_size = 10'd1;
    y_size = 10'd3;
    add(0, 0, 15'h0001); add(0, 1, 15'h0002); add(0, 2, 15'h0003);
    drain();
    x_size = 10'd0;
    add(0, 0, 15'h0004);
    drain();
    tready_mode = 0;
    x_size = 10'd4;
    y_size = 10'd2;
    add(0, 0, 15'h0F0F); add(1, 0, 15'h00FF); add(2, 0, 15'h7000);
    for (int i = 0; i < 20 && q.size() < 3; i++) cycle();
    check("rst_fill", q.size(), 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_tvalid", io.m_axis_tvalid, 1'b0);
    check("arst_tdata", io.m_axis_tdata, 24'h0);
    check("arst_tuser", io.m_axis_tuser, 1'b0);
    check("arst_tlast", io.m_axis_tlast, 1'b0);
    q.delete();
    script.delete();
    in_frame = 0;
    exp_done = 0;
    exp_err = 0;
    io.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tready_mode = 1;
    add(3, 0, 15'h0001); add(1, 0, 15'h0002);
    drain();
    repeat (4) cycle();
    rand_fill = 1;
    tready_mode = 2;
    repeat (4000) cycle();
    rand_fill = 0;
    script.delete();
    enable = 1'b1;
    tready_mode = 1;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
